sam3_feeder: RTL and testbench

//  Upstream stage of the 3x3 systolic multiplier (sam3). Buffers one 3x3 A and one 3x3 B (4-bit elements)

---
 rtl/sam3_feeder_if.sv | 36 +++
 rtl/sam3_feeder.sv | 209 ++++++++++++++++++++
 tb/tb_sam3_feeder.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sam3_feeder_if.sv
// Write port, run control and array-side signals of the sam3 feeder.
// slave: the feeder itself; master: whatever drives it and models the array.
interface sam3_feeder_if #(
    parameter int DATA_W = 4
);
    logic              wr_en;
    logic              wr_sel;
    logic [3:0]        wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic              mult_over;
    logic [DATA_W-1:0] a_row0;
    logic [DATA_W-1:0] a_row1;
    logic [DATA_W-1:0] a_row2;
    logic [DATA_W-1:0] b_col0;
    logic [DATA_W-1:0] b_col1;
    logic [DATA_W-1:0] b_col2;
    logic              arr_en;
    logic              arr_reset;
    logic              busy;
    logic              c_valid;
    logic              done;
    logic              err;

    modport slave (
        input  wr_en, wr_sel, wr_addr, wr_data, start, mult_over,
        output a_row0, a_row1, a_row2, b_col0, b_col1, b_col2,
        output arr_en, arr_reset, busy, c_valid, done, err
    );

    modport master (
        output wr_en, wr_sel, wr_addr, wr_data, start, mult_over,
        input  a_row0, a_row1, a_row2, b_col0, b_col1, b_col2,
        input  arr_en, arr_reset, busy, c_valid, done, err
    );
endinterface

// File: rtl/sam3_feeder.sv
// Buffers 3x3 A/B and streams them skewed into the sam3 systolic array.
// Optional WAIT watchdog enabled by defining SAM3_FEEDER_TIMEOUT_EN.
module sam3_feeder #(
    parameter int DATA_W         = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic         clock,
    input  logic         reset,
    sam3_feeder_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] abuf_q [9];
    logic [DATA_W-1:0] abuf_d [9];
    logic [DATA_W-1:0] bbuf_q [9];
    logic [DATA_W-1:0] bbuf_d [9];
    logic [DATA_W-1:0] arow_q [3];
    logic [DATA_W-1:0] arow_d [3];
    logic [DATA_W-1:0] bcol_q [3];
    logic [DATA_W-1:0] bcol_d [3];
    logic              en_q, en_d;
    logic              arst_q, arst_d;
    logic              busy_q, busy_d;
    logic              cv_q, cv_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
`ifdef SAM3_FEEDER_TIMEOUT_EN
    localparam logic [5:0] TO_LIM = 6'(TIMEOUT_CYCLES);
    logic [5:0]        wd_q, wd_d;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            for (int i = 0; i < 9; i++) begin
                abuf_q[i] <= '0;
                bbuf_q[i] <= '0;
            end
            for (int i = 0; i < 3; i++) begin
                arow_q[i] <= '0;
                bcol_q[i] <= '0;
            end
            en_q    <= 1'b0;
            arst_q  <= 1'b1;
            busy_q  <= 1'b0;
            cv_q    <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef SAM3_FEEDER_TIMEOUT_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            abuf_q  <= abuf_d;
            bbuf_q  <= bbuf_d;
            arow_q  <= arow_d;
            bcol_q  <= bcol_d;
            en_q    <= en_d;
            arst_q  <= arst_d;
            busy_q  <= busy_d;
            cv_q    <= cv_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef SAM3_FEEDER_TIMEOUT_EN
            wd_q    <= wd_d;
`endif
        end
    end

    // Buffers are only writable while idle, so a run sees frozen operands.
    always_comb begin
        abuf_d = abuf_q;
        bbuf_d = bbuf_q;
        if (state_q == S_IDLE && bus.wr_en && bus.wr_addr < 4'd9) begin
            if (bus.wr_sel) begin
                bbuf_d[bus.wr_addr] = bus.wr_data;
            end else begin
                abuf_d[bus.wr_addr] = bus.wr_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
`ifdef SAM3_FEEDER_TIMEOUT_EN
        wd_d    = wd_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_FEED;
                    cnt_d   = '0;
                end
            end
            S_FEED: begin
                if (cnt_q == 3'd4) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
`ifdef SAM3_FEEDER_TIMEOUT_EN
                    wd_d    = '0;
`endif
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_WAIT: begin
                if (bus.mult_over) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end
`ifdef SAM3_FEEDER_TIMEOUT_EN
                else if (wd_q + 6'd1 == TO_LIM) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 6'd1;
                end
`endif
            end
            S_DRAIN: begin
                if (cnt_q == 3'd2) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Wavefront t carries the anti-diagonal i+col == t of A and row+j == t of B.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            arow_d[i] = '0;
            bcol_d[i] = '0;
        end
        if (state_d == S_FEED) begin
            case (cnt_d)
                3'd0: begin
                    arow_d[0] = abuf_d[0];
                    bcol_d[0] = bbuf_d[0];
                end
                3'd1: begin
                    arow_d[0] = abuf_d[1];
                    arow_d[1] = abuf_d[3];
                    bcol_d[0] = bbuf_d[3];
                    bcol_d[1] = bbuf_d[1];
                end
                3'd2: begin
                    arow_d[0] = abuf_d[2];
                    arow_d[1] = abuf_d[4];
                    arow_d[2] = abuf_d[6];
                    bcol_d[0] = bbuf_d[6];
                    bcol_d[1] = bbuf_d[4];
                    bcol_d[2] = bbuf_d[2];
                end
                3'd3: begin
                    arow_d[1] = abuf_d[5];
                    arow_d[2] = abuf_d[7];
                    bcol_d[1] = bbuf_d[7];
                    bcol_d[2] = bbuf_d[5];
                end
                3'd4: begin
                    arow_d[2] = abuf_d[8];
                    bcol_d[2] = bbuf_d[8];
                end
                default: begin
                end
            endcase
        end
        en_d   = state_d inside {S_FEED, S_WAIT, S_DRAIN};
        arst_d = !en_d;
        busy_d = state_d != S_IDLE;
        cv_d   = state_d == S_DRAIN;
        done_d = state_d == S_DONE;
    end

    assign bus.a_row0    = arow_q[0];
    assign bus.a_row1    = arow_q[1];
    assign bus.a_row2    = arow_q[2];
    assign bus.b_col0    = bcol_q[0];
    assign bus.b_col1    = bcol_q[1];
    assign bus.b_col2    = bcol_q[2];
    assign bus.arr_en    = en_q;
    assign bus.arr_reset = arst_q;
    assign bus.busy      = busy_q;
    assign bus.c_valid   = cv_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_sam3_feeder.sv
// Bench for sam3_feeder: a behavioural systolic array consumes the feed,
// and its result columns are scored against a plain matrix product.
module tb_sam3_feeder;
    localparam int DW = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    sam3_feeder_if #(.DATA_W(DW)) bus ();

    sam3_feeder #(
        .DATA_W        (DW),
        .TIMEOUT_CYCLES(32)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int passed = 0;
    int total  = 0;
    int mA [9];
    int mB [9];
    int nA [9];
    int nB [9];
    logic [29:0] exp_q [$];
    int cap_a [3][64];
    int cap_b [3][64];
    int ncap = 0;
    int kcnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int exp_c(input int i, input int k);
        int s = 0;
        for (int m = 0; m < 3; m++) s += mA[i*3+m] * mB[m*3+k];
        return s;
    endfunction

    // PE(i,j) meets a_row_i from p cycles in with b_col_j from p+j-i cycles in.
    function automatic int model_c(input int i, input int j);
        int s = 0;
        for (int p = 0; p < ncap; p++) begin
            int q = p + j - i;
            if (q >= 0 && q < ncap) s += cap_a[i][p] * cap_b[j][q];
        end
        return s;
    endfunction

    // Array model: clears on arr_reset, shifts in one wavefront per enabled cycle.
    initial forever begin
        @(posedge clock);
        if (bus.arr_reset === 1'b1) begin
            ncap = 0;
        end else if (bus.arr_en === 1'b1 && ncap < 64) begin
            cap_a[0][ncap] = int'(bus.a_row0);
            cap_a[1][ncap] = int'(bus.a_row1);
            cap_a[2][ncap] = int'(bus.a_row2);
            cap_b[0][ncap] = int'(bus.b_col0);
            cap_b[1][ncap] = int'(bus.b_col1);
            cap_b[2][ncap] = int'(bus.b_col2);
            ncap++;
        end
    end

    initial forever begin
        logic [29:0] e;
        @(negedge clock);
        if (bus.c_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_c_valid: got c_valid=1, expected 0");
            end else begin
                e = exp_q.pop_front();
                chk("c_row0", model_c(0, kcnt), int'(e[29:20]));
                chk("c_row1", model_c(1, kcnt), int'(e[19:10]));
                chk("c_row2", model_c(2, kcnt), int'(e[9:0]));
            end
            kcnt++;
        end
        if (bus.done === 1'b1) kcnt = 0;
    end

    task automatic drive_idle();
        bus.start     = 1'b0;
        bus.wr_en     = 1'b0;
        bus.mult_over = 1'b0;
    endtask

    // mode 0: reuse buffers, 1: random operands, 2: operands from nA/nB
    task automatic run(input int mode, input bit hz, input int dly);
        int m = 5 + dly;
        chk("pre_busy", int'(bus.busy), 0);
        if (mode != 0) begin
            if (mode == 1) begin
                for (int e = 0; e < 9; e++) begin
                    nA[e] = $urandom_range(0, 15);
                    nB[e] = $urandom_range(0, 15);
                end
            end
            for (int e = 0; e < 18; e++) begin
                if (e > 0) @(negedge clock);
                if (e == 9) begin
                    bus.wr_addr = 4'($urandom_range(9, 15));
                    bus.wr_data = DW'($urandom_range(1, 15));
                    @(negedge clock);
                end
                bus.wr_en     = 1'b1;
                bus.wr_sel    = (e >= 9);
                bus.wr_addr   = 4'(e % 9);
                bus.wr_data   = DW'((e >= 9) ? nB[e-9] : nA[e]);
                bus.mult_over = 1'($urandom_range(0, 1));
                bus.start     = (e == 17);
                if (e < 9) mA[e] = nA[e];
                else mB[e-9] = nB[e-9];
            end
        end else begin
            bus.start = 1'b1;
        end
        for (int k = 0; k < 3; k++)
            exp_q.push_back({10'(exp_c(0, k)), 10'(exp_c(1, k)), 10'(exp_c(2, k))});
        @(negedge clock);
        drive_idle();
        chk("feed_en", int'(bus.arr_en), 1);
        chk("feed_arst", int'(bus.arr_reset), 0);
        chk("feed_busy", int'(bus.busy), 1);
        for (int n = 1; n <= m + 5; n++) begin
            @(negedge clock);
            drive_idle();
            if (n == 2) begin
                chk("t2_a_row0", int'(bus.a_row0), mA[2]);
                chk("t2_a_row1", int'(bus.a_row1), mA[4]);
                chk("t2_a_row2", int'(bus.a_row2), mA[6]);
                chk("t2_b_col0", int'(bus.b_col0), mB[6]);
                chk("t2_b_col1", int'(bus.b_col1), mB[4]);
                chk("t2_b_col2", int'(bus.b_col2), mB[2]);
            end
            if (n == 4) begin
                chk("t4_a_row2", int'(bus.a_row2), mA[8]);
                chk("t4_b_col2", int'(bus.b_col2), mB[8]);
                chk("t4_a_row0", int'(bus.a_row0), 0);
            end
            if (hz && (n == 1 || n == 5)) begin
                bus.wr_en   = 1'b1;
                bus.wr_sel  = 1'($urandom_range(0, 1));
                bus.wr_addr = 4'($urandom_range(0, 8));
                bus.wr_data = DW'($urandom_range(0, 15));
                bus.start   = 1'b1;
            end
            if (n == m) begin
                chk("wait_en", int'(bus.arr_en), 1);
                chk("wait_cvalid", int'(bus.c_valid), 0);
                chk("wait_a_row1", int'(bus.a_row1), 0);
                bus.mult_over = 1'b1;
            end
            if (n > m && n <= m + 3) chk("drain_cvalid", int'(bus.c_valid), 1);
            if (n == m + 4) begin
                chk("done_pulse", int'(bus.done), 1);
                chk("done_cvalid", int'(bus.c_valid), 0);
                chk("done_arst", int'(bus.arr_reset), 1);
                chk("done_en", int'(bus.arr_en), 0);
                if (hz) bus.start = 1'b1;
            end
            if (n == m + 5) begin
                chk("end_busy", int'(bus.busy), 0);
                chk("end_done", int'(bus.done), 0);
                chk("end_err", int'(bus.err), 0);
                chk("end_sb_empty", exp_q.size(), 0);
            end
        end
    endtask

    task automatic reset_midfeed();
        bus.wr_en   = 1'b1;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = 4'd4;
        bus.wr_data = DW'(9);
        bus.start   = 1'b1;
        @(negedge clock);
        drive_idle();
        @(negedge clock);
        chk("mid_busy", int'(bus.busy), 1);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_en", int'(bus.arr_en), 0);
        chk("rst_arst", int'(bus.arr_reset), 1);
        chk("rst_a_row1", int'(bus.a_row1), 0);
        for (int e = 0; e < 9; e++) begin
            mA[e] = 0;
            mB[e] = 0;
        end
        exp_q.delete();
    endtask

    initial begin
        int first_err;
        int n_err;
        bus.wr_sel  = 1'b0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        drive_idle();
        for (int e = 0; e < 9; e++) begin
            mA[e] = 0;
            mB[e] = 0;
        end
        repeat (3) @(negedge clock);
        chk("reset_arst", int'(bus.arr_reset), 1);
        chk("reset_en", int'(bus.arr_en), 0);
        chk("reset_busy", int'(bus.busy), 0);
        chk("reset_cvalid", int'(bus.c_valid), 0);
        chk("reset_done", int'(bus.done), 0);
        chk("reset_err", int'(bus.err), 0);
        chk("reset_a_row0", int'(bus.a_row0), 0);
        chk("reset_b_col2", int'(bus.b_col2), 0);
        reset = 1'b1;
        @(negedge clock);

        reset_midfeed();
        run(0, 1'b0, 2);

        for (int e = 0; e < 9; e++) begin
            nA[e] = (e % 4 == 0) ? 1 : 0;
            nB[e] = e + 1;
        end
        run(2, 1'b0, 3);

        for (int e = 0; e < 9; e++) begin
            nA[e] = 15;
            nB[e] = 15;
        end
        run(2, 1'b0, 1);

        run(1, 1'b1, 2);
        run(0, 1'b0, 1);

        repeat (6) run($urandom_range(0, 1), 1'($urandom_range(0, 1)),
                       $urandom_range(1, 4));

        bus.start = 1'b1;
        @(negedge clock);
        drive_idle();
`ifdef SAM3_FEEDER_TIMEOUT_EN
        first_err = -1;
        n_err     = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (bus.err === 1'b1) begin
                n_err++;
                if (first_err < 0) first_err = n;
                chk("to_done_with_err", int'(bus.done), 1);
            end
        end
        chk("to_err_cycle", first_err, 37);
        chk("to_err_count", n_err, 1);
        chk("to_busy_after", int'(bus.busy), 0);
`else
        first_err = 0;
        n_err     = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clock);
            if (bus.busy !== 1'b1) first_err++;
            if (bus.done === 1'b1 || bus.err === 1'b1) n_err++;
        end
        chk("hold_busy_drops", first_err, 0);
        chk("hold_done_or_err", n_err, 0);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        chk("hold_recover_busy", int'(bus.busy), 0);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
